// File: rtl/wb_macro_select.sv
// Wishbone classic router: host port -> one of NUM_SLAVES macro slots,
// plus a local error/status CSR and a per-transfer ack timeout.
module wb_macro_select #(
    parameter int          NUM_SLAVES   = 3,
    parameter logic [7:0]  BASE_ADDR    = 8'h30,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLAVES-1:0]    m_cyc_o,
    output logic [NUM_SLAVES-1:0]    m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [NUM_SLAVES-1:0]    m_ack_i,
    input  logic [32*NUM_SLAVES-1:0] m_dat_i,
    output logic                     timeout_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // DONE holds the captured response one cycle so the host ack
    // lands exactly one cycle after the slave ack is sampled.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [NUM_SLAVES-1:0] r_oh;
    logic [NUM_SLAVES-1:0] w_oh;
    logic [1:0]            r_slot;
    logic [1:0]            r_last;
    logic [15:0]           r_err;
    logic [CW-1:0]         r_cnt;
    logic [31:0]           r_rdata;
    logic [31:0]           r_dout;
    logic                  r_ack;
    logic                  r_tmo;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic [31:0]           r_adr;
    logic [31:0]           r_wdat;

    logic                  w_req;
    logic                  w_hit;
    logic [1:0]            w_slot;
    logic                  w_is_mac;
    logic                  w_is_csr;
    logic                  w_ack;
    logic                  w_tmo;
    logic [31:0]           w_sdat;
    logic [31:0]           w_csr_rd;

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_hit    = (wbs_adr_i[31:24] == BASE_ADDR);
    assign w_slot   = wbs_adr_i[21:20];
    assign w_is_mac = w_hit && ({30'd0, w_slot} < 32'(NUM_SLAVES));
    assign w_is_csr = w_hit && (w_slot == 2'd3);
    assign w_ack    = |(m_ack_i & r_oh);
    assign w_tmo    = (r_cnt == CNT_LAST);
    assign w_csr_rd = (wbs_adr_i[3:2] == 2'b00) ?
                      {14'd0, r_last, r_err} : 32'h0;

    // One-hot strobe pattern for the decoded slot
    always_comb begin
        w_oh = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_slot == 2'(k)) w_oh[k] = 1'b1;
        end
    end

    // Read-data mux restricted to the selected slot
    always_comb begin
        w_sdat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_oh[k]) w_sdat = m_dat_i[32*k +: 32];
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = w_is_mac ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (!wbs_cyc_i)         w_next = S_IDLE;
                else if (w_ack || w_tmo) w_next = S_DONE;
            end
            S_DONE:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Request latch, response capture, timeout counter and CSR state
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_oh    <= '0;
            r_slot  <= '0;
            r_last  <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_dout  <= '0;
            r_ack   <= 1'b0;
            r_tmo   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_we    <= wbs_we_i;
                        r_sel   <= wbs_sel_i;
                        r_adr   <= wbs_adr_i;
                        r_wdat  <= wbs_dat_i;
                        r_slot  <= w_slot;
                        r_oh    <= w_is_mac ? w_oh : '0;
                        r_rdata <= w_is_csr ? w_csr_rd : TIMEOUT_DATA;
                        if (w_is_csr && wbs_we_i &&
                            wbs_adr_i[3:2] == 2'b00) begin
                            r_err  <= '0;
                            r_last <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (!wbs_cyc_i) begin
                        r_oh <= '0;
                    end else if (w_ack) begin
                        r_rdata <= w_sdat;
                    end else if (w_tmo) begin
                        r_rdata <= TIMEOUT_DATA;
                        r_tmo   <= 1'b1;
                        r_last  <= r_slot;
                        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ack  <= 1'b1;
                    r_dout <= r_rdata;
                end
                S_RESP: begin
                    r_ack  <= 1'b0;
                    r_dout <= '0;
                end
                default: ;
            endcase
        end
    end

    assign m_cyc_o   = (r_state == S_REQ) ? r_oh : '0;
    assign m_stb_o   = (r_state == S_REQ) ? r_oh : '0;
    assign m_we_o    = r_we;
    assign m_sel_o   = r_sel;
    assign m_adr_o   = r_adr;
    assign m_dat_o   = r_wdat;
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dout;
    assign timeout_o = r_tmo;

endmodule

// File: tb/tb_wb_macro_select.sv
// Scoreboard bench for wb_macro_select: directed scenarios then random
// traffic, expected acks queued by the driver and checked by a monitor.
module tb_wb_macro_select;

    localparam int          NS  = 3;
    localparam int          TMO = 8;
    localparam logic [31:0] TD  = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            ack;
    logic [31:0]     rdat;
    logic [NS-1:0]   m_cyc, m_stb, m_ack;
    logic            m_we;
    logic [3:0]      m_sel;
    logic [31:0]     m_adr, m_wdat;
    logic [32*NS-1:0] m_rdat;
    logic            tmo;

    wb_macro_select #(
        .NUM_SLAVES(NS), .BASE_ADDR(8'h30),
        .TIMEOUT(TMO), .TIMEOUT_DATA(TD)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we),
        .m_sel_o(m_sel), .m_adr_o(m_adr), .m_dat_o(m_wdat),
        .m_ack_i(m_ack), .m_dat_i(m_rdat), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        bit          chk_dat;
        int          cyc;
        bit          tmo;
    } exp_t;

    exp_t exp_q[$];
    int   chk_n = 0;
    int   fail_n = 0;
    int   cyc_cnt = 0;
    int   tmo_cyc = -100;
    bit   prev_ack = 1'b0;
    int   m_err = 0;
    int   m_last = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        chk_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    // Monitor: pops one expectation per host ack
    always @(negedge clk) begin
        if (rst_n) begin
            if (tmo) tmo_cyc = cyc_cnt;
            if (ack) begin
                chk("ack_single", prev_ack, 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", ack, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.chk_dat) chk("rdata", rdat, e.dat);
                    chk("latency", cyc_cnt, e.cyc);
                    chk("timeout_pulse", (tmo_cyc == cyc_cnt - 1), e.tmo);
                end
            end else if (prev_ack) begin
                chk("dat_after_ack", rdat, 0);
            end
            prev_ack = ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    // One host transfer; the driver also plays the addressed slave.
    // d = edge index (after accept) at which the slave ack is sampled.
    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [31:0] dv, input logic [3:0] s,
                       input int d, input logic [31:0] sdat,
                       input int stray);
        exp_t      e;
        bit        hit, mac, csr;
        int        slot, e0;
        logic [NS-1:0] estb;
        bit        seen;
        hit  = (a[31:24] == 8'h30);
        slot = int'(a[21:20]);
        mac  = hit && slot < NS;
        csr  = hit && slot == 3;
        estb = '0;
        if (mac) estb[slot] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NS; k++) m_rdat[32*k +: 32] = $urandom;
        cyc = 1; stb = 1; we = w; adr = a; wdat = dv; sel = s;
        e0 = cyc_cnt + 1;
        e.tmo = 0;
        e.chk_dat = 1;
        if (mac) begin
            if (d <= TMO) begin
                e.dat = sdat; e.cyc = e0 + d + 1;
            end else begin
                e.dat = TD; e.cyc = e0 + TMO + 1; e.tmo = 1;
                if (m_err < 65535) m_err++;
                m_last = slot;
            end
        end else if (csr) begin
            e.cyc = e0 + 1;
            e.chk_dat = !w;
            e.dat = (a[3:2] == 0) ? 32'((m_last << 16) | m_err) : 32'h0;
            if (w && a[3:2] == 0) begin m_err = 0; m_last = 0; end
        end else begin
            e.cyc = e0 + 1; e.dat = TD;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("mreq", {m_stb, m_cyc, m_we, m_sel, m_adr, m_wdat},
            {estb, estb, w, s, a, dv});
        if (mac) begin
            for (int i = 1; i < d && i <= TMO; i++) begin
                if (i == 1 && stray >= 0) m_ack[stray] = 1'b1;
                @(posedge clk); #1;
                m_ack = '0;
            end
            if (d <= TMO) begin
                m_ack[slot] = 1'b1;
                m_rdat[32*slot +: 32] = sdat;
                @(posedge clk); #1;
                m_ack = '0;
            end
        end
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        if (!seen) chk("ack_wait", 0, 1);
        @(posedge clk); #1;
        cyc = 0; stb = 0;
    endtask

    initial begin
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        m_ack = '0; m_rdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {ack, rdat, m_cyc, m_stb, m_we, m_sel,
                           m_adr, m_wdat, tmo}, 0);
        rst_n = 1;
        // read slot1, write slot0, boundary ack at TIMEOUT
        txn(0, 32'h3010_0004, 32'h0, 4'hF, 2, 32'h1234_5678, -1);
        txn(1, 32'h3000_0000, 32'hA5A5_A5A5, 4'b0011, 1,
            32'h0BAD_0000, -1);
        txn(0, 32'h3010_0008, 32'h0, 4'hF, TMO, 32'hCAFE_F00D, -1);
        // silent slot2, then status CSR
        txn(0, 32'h3020_0000, 32'h0, 4'hF, TMO + 5, 32'h0, -1);
        txn(0, 32'h3030_0000, 32'h0, 4'hF, 0, 32'h0, -1);
        // undecoded address, CSR clear and re-read, other offset
        txn(0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h0, -1);
        txn(1, 32'h5000_0010, 32'h1111, 4'hF, 0, 32'h0, -1);
        txn(1, 32'h3030_0000, 32'h0, 4'hF, 0, 32'h0, -1);
        txn(0, 32'h3030_0000, 32'h0, 4'hF, 0, 32'h0, -1);
        txn(0, 32'h3030_0004, 32'h0, 4'hF, 0, 32'h0, -1);
        // stray ack from slot2 during a slot0 read
        txn(0, 32'h3000_0020, 32'h0, 4'hF, 4, 32'h7777_1234, 2);
        // host abort mid-REQ, late ack ignored
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0010;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        chk("abort_mcyc", {m_cyc, m_stb}, 0);
        m_ack[0] = 1'b1;
        @(posedge clk); #1;
        m_ack = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_noack", ack, 0);
        txn(0, 32'h3030_0000, 32'h0, 4'hF, 0, 32'h0, -1);
        // async reset mid-REQ after one timeout was logged
        txn(0, 32'h3010_0000, 32'h0, 4'hF, TMO + 1, 32'h0, -1);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h3010_0040;
        wdat = 32'h9999_8888; sel = 4'hC;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("reset_mid", {ack, rdat, m_cyc, m_stb, m_we, m_sel,
                          m_adr, m_wdat, tmo}, 0);
        cyc = 0; stb = 0;
        m_err = 0; m_last = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        txn(0, 32'h3010_0000, 32'h0, 4'hF, 3, 32'h2468_ACE0, -1);
        txn(0, 32'h3030_0000, 32'h0, 4'hF, 0, 32'h0, -1);
        // random traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          kind;
            int          d;
            a    = $urandom;
            kind = $urandom_range(0, 9);
            d    = 0;
            if (kind < 6) begin
                a[31:24] = 8'h30;
                a[21:20] = 2'($urandom_range(0, NS - 1));
                d = $urandom_range(1, TMO + 2);
            end else if (kind < 9) begin
                a[31:24] = 8'h30;
                a[21:20] = 2'd3;
                if ($urandom_range(0, 1) == 1) a[3:2] = 2'd0;
            end else if (a[31:24] == 8'h30) begin
                a[31:24] = 8'h31;
            end
            txn(1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom), d, $urandom, -1);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", chk_n - fail_n, chk_n);
        $finish;
    end

endmodule
